// File: rtl/quad_decoder_pkg.sv
// Shared types and Gray-code transition tables for the rotary-encoder decoder.
// quad_decode classifies one filtered-phase transition as step up, step down, or error.
package quad_pkg;

  typedef logic [1:0] quad_state_t;

  // Successor of state s is held in bits [2s+1:2s]; state is {A, B}.
  // Up:   00->10, 01->00, 10->11, 11->01
  localparam logic [7:0] UP_NEXT = 8'b01_11_00_10;
  // Down: 00->01, 01->11, 10->00, 11->10
  localparam logic [7:0] DN_NEXT = 8'b10_00_11_01;

  // Returns {valid, dir, err}; dir is meaningful only when valid is set.
  function automatic logic [2:0] quad_decode(input quad_state_t prev, input quad_state_t cur);
    quad_state_t up_nxt;
    quad_state_t dn_nxt;
    logic [2:0]  res;
    up_nxt = UP_NEXT[{prev, 1'b0} +: 2];
    dn_nxt = DN_NEXT[{prev, 1'b0} +: 2];
    res    = 3'b000;
    if (cur == prev) begin
      res = 3'b000;
    end else if (cur == up_nxt) begin
      res = 3'b110;
    end else if (cur == dn_nxt) begin
      res = 3'b100;
    end else begin
      res = 3'b001;
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_decoder_sync_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
// The filtered bit follows the synchronised input only after DEBOUNCE straight mismatching cycles.
module sync_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_filtered
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d  = d_async;
    s2_d  = s1_q;
    f_d   = f_q;
    cnt_d = cnt_q;
    if (s2_q == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
      f_d   = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_filtered = f_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases -> step pulse, direction level, wrapping position.
// No handshake: step and err are single-cycle pulses that consumers sample every cycle.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [WIDTH-1:0] count
);

  logic        fa, fb;
  quad_state_t cur;
  quad_state_t prev_q, prev_d;
  logic [2:0]  dec;

  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] count_q, count_d;

  sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
    .clk       (clk),
    .rst       (rst),
    .d_async   (a_in),
    .q_filtered(fa)
  );

  sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
    .clk       (clk),
    .rst       (rst),
    .d_async   (b_in),
    .q_filtered(fb)
  );

  assign cur = {fa, fb};
  assign dec = quad_decode(prev_q, cur);

  always_comb begin
    prev_d  = cur;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir_q;
    count_d = count_q;
    if (dec[2]) begin
      step_d  = 1'b1;
      dir_d   = dec[1];
      count_d = dec[1] ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end else if (dec[0]) begin
      // Both phases moved at once: the direction is unknowable, so position holds.
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 2'b00;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b1;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      step_q  <= step_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
      count_q <= count_d;
    end
  end

  assign step  = step_q;
  assign err   = err_q;
  assign dir   = dir_q;
  assign count = count_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: a Gray-position model pushes {step, err, dir, count}
// events into a queue as phases are driven; a monitor pops and compares each output pulse.
module tb_quad_decoder;

  localparam int WIDTH    = 8;
  localparam int DEBOUNCE = 4;
  localparam int EW       = 3 + WIDTH;

  logic             clk;
  logic             rst;
  logic             a_in;
  logic             b_in;
  logic             step;
  logic             dir;
  logic             err;
  logic [WIDTH-1:0] count;

  logic [EW-1:0]    exp_q[$];
  int               n_cmp;
  int               n_bad;

  logic [1:0]       m_state;
  logic [WIDTH-1:0] m_count;
  logic             m_dir;

  quad_decoder #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) dut (
    .clk  (clk),
    .rst  (rst),
    .a_in (a_in),
    .b_in (b_in),
    .step (step),
    .dir  (dir),
    .err  (err),
    .count(count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] state_of(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 2'b00;
    m_count = '0;
    m_dir   = 1'b1;
  endtask

  task automatic model_move(input logic [1:0] nxt);
    int d;
    d = (pos(nxt) - pos(m_state) + 4) % 4;
    if (d == 1) begin
      m_count = m_count + 1'b1;
      m_dir   = 1'b1;
      exp_q.push_back({1'b1, 1'b0, 1'b1, m_count});
    end else if (d == 3) begin
      m_count = m_count - 1'b1;
      m_dir   = 1'b0;
      exp_q.push_back({1'b1, 1'b0, 1'b0, m_count});
    end else if (d == 2) begin
      exp_q.push_back({1'b0, 1'b1, m_dir, m_count});
    end
    m_state = nxt;
  endtask

  // ---------------- driver ----------------
  task automatic move(input logic a, input logic b, input int hold);
    model_move({a, b});
    a_in = a;
    b_in = b;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic run_monitor();
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && (step || err)) begin
        obs = {step, err, dir, count};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got step=%0b err=%0b dir=%0b count=%0d, expected no event",
                   step, err, dir, count);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            n_bad++;
            $display("FAIL event: got step/err/dir/count=%0b/%0b/%0b/%0d expected %0b/%0b/%0b/%0d",
                     obs[EW-1], obs[EW-2], obs[EW-3], obs[WIDTH-1:0],
                     exp[EW-1], exp[EW-2], exp[EW-3], exp[WIDTH-1:0]);
          end
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst  = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if (step !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %0b expected 0", step); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b expected 0", err); end
    n_cmp++;
    if (dir !== 1'b1) begin n_bad++; $display("FAIL reset_dir: got %0b expected 1", dir); end
    n_cmp++;
    if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if ({step, err, dir, count} !== {1'b0, 1'b0, 1'b1, {WIDTH{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_static: got step/err/dir/count=%0b/%0b/%0b/%0d expected 0/0/1/0",
               step, err, dir, count);
    end
  endtask

  task automatic test_up();
    model_move(2'b10);
    a_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (step !== 1'b0) begin
        n_bad++;
        $display("FAIL up_latency_early: got step=%0b at edge %0d expected 0", step, i);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (step !== 1'b1) begin n_bad++; $display("FAIL up_latency_edge6: got step=%0b expected 1", step); end
    repeat (3) @(posedge clk);
    #1;
    move(1'b1, 1'b1, 10);
    move(1'b0, 1'b1, 10);
    move(1'b0, 1'b0, 10);
    n_cmp++;
    if (count !== 8'd4) begin n_bad++; $display("FAIL up_count: got %0d expected 4", count); end
    n_cmp++;
    if (dir !== 1'b1) begin n_bad++; $display("FAIL up_dir: got %0b expected 1", dir); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL up_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_down_wrap();
    test_reset();
    move(1'b0, 1'b1, 10);
    n_cmp++;
    if (count !== 8'd255) begin n_bad++; $display("FAIL down_wrap_count: got %0d expected 255", count); end
    n_cmp++;
    if (dir !== 1'b0) begin n_bad++; $display("FAIL down_wrap_dir: got %0b expected 0", dir); end
    move(1'b0, 1'b0, 10);
    n_cmp++;
    if (count !== 8'd0) begin n_bad++; $display("FAIL up_wrap_count: got %0d expected 0", count); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL down_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    a_in = 1'b1;
    repeat (DEBOUNCE - 1) @(posedge clk);
    #1;
    a_in = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (count !== m_count) begin n_bad++; $display("FAIL glitch_count: got %0d expected %0d", count, m_count); end
    n_cmp++;
    if (dir !== m_dir) begin n_bad++; $display("FAIL glitch_dir: got %0b expected %0b", dir, m_dir); end
    model_move(2'b10);
    a_in = 1'b1;
    repeat (DEBOUNCE) @(posedge clk);
    #1;
    move(1'b0, 1'b0, 14);
    n_cmp++;
    if (count !== m_count) begin n_bad++; $display("FAIL pulse4_count: got %0d expected %0d", count, m_count); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL pulse4_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    logic [WIDTH-1:0] c0;
    logic             d0;
    c0 = m_count;
    d0 = m_dir;
    move(1'b1, 1'b1, 12);
    n_cmp++;
    if ({dir, count} !== {d0, c0}) begin
      n_bad++;
      $display("FAIL illegal_hold: got dir/count=%0b/%0d expected %0b/%0d", dir, count, d0, c0);
    end
    move(1'b0, 1'b0, 12);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL illegal_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_at_11();
    a_in = 1'b1;
    b_in = 1'b1;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    model_move(2'b11);
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if ({dir, count} !== {1'b1, {WIDTH{1'b0}}}) begin
      n_bad++;
      $display("FAIL rst11_hold: got dir/count=%0b/%0d expected 1/0", dir, count);
    end
    move(1'b0, 1'b0, 12);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rst11_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    a_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({step, err, dir, count} !== {1'b0, 1'b0, 1'b1, {WIDTH{1'b0}}}) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got step/err/dir/count=%0b/%0b/%0b/%0d expected 0/0/1/0",
               step, err, dir, count);
    end
    model_reset();
    model_move(2'b10);
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (count !== 8'd1) begin n_bad++; $display("FAIL rst_mid_count: got %0d expected 1", count); end
    move(1'b0, 1'b0, 12);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rst_mid_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] nxt;
    int         p;
    for (int i = 0; i < 8; i++) begin
      nxt = state_of((pos(m_state) + 1) % 4);
      move(nxt[1], nxt[0], DEBOUNCE);
    end
    for (int i = 0; i < 24; i++) begin
      p   = pos(m_state);
      p   = ($urandom_range(0, 1) == 1) ? (p + 1) % 4 : (p + 3) % 4;
      nxt = state_of(p);
      move(nxt[1], nxt[0], $urandom_range(DEBOUNCE, DEBOUNCE + 6));
    end
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (count !== m_count) begin n_bad++; $display("FAIL b2b_count: got %0d expected %0d", count, m_count); end
    n_cmp++;
    if (dir !== m_dir) begin n_bad++; $display("FAIL b2b_dir: got %0b expected %0b", dir, m_dir); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    a_in  = 1'b0;
    b_in  = 1'b0;
    model_reset();
    fork
      run_monitor();
    join_none
    test_reset();
    test_up();
    test_down_wrap();
    test_glitch();
    test_illegal();
    test_reset_at_11();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder for the board's rotary encoder. Synchronises and debounces the asynchronous A/B phase inputs, then decodes Gray-code transitions. The outputs are a one-cycle step pulse, a direction level and a wrapping position count. `dir` uses the counter's `en` convention (1 = up, 0 = down), so `step`/`dir` can drive an up/down counter directly. `count` can also be displayed on its own.

## Interface
- `WIDTH`, 8: width of `count`.
- `DEBOUNCE`, 4: consecutive cycles a synchronised phase must differ from its filtered value before the filtered value changes. Legal values are 1 or more.

- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `a_in`  in  1: encoder phase A, asynchronous.
- `b_in`  in  1: encoder phase B, asynchronous.
- `step`  out  1: one-cycle pulse per valid transition.
- `dir`  out  1: direction of the last valid transition. 1 = up, 0 = down.
- `err`  out  1: one-cycle pulse when both filtered phases change in the same cycle.
- `count`  out  WIDTH: signed-agnostic position, wraps modulo 2^WIDTH.

## Operation
- **Synchroniser:** two flops per phase (s1, s2), reset to 0.
- **Debounce:** one per phase. It has a filtered bit `f` and a counter `cnt` of width $clog2(DEBOUNCE+1). At each edge:
  - if s2 == f: cnt <= 0.
  - else if cnt == DEBOUNCE-1: f <= s2, cnt <= 0.
  - else: cnt <= cnt+1.
  - A mismatch lasting fewer than DEBOUNCE cycles never changes `f`.
- **Decoder state:** cur = {fA, fB}. `prev` is a 2-bit register loaded with `cur` every cycle.
- **Up sequence** (A leads): 00→10→11→01→00.
- **Down sequence:** 00→01→11→10→00.
- **Registered outputs, each edge:**
  - cur == prev: step <= 0, err <= 0, dir and count hold.
  - Single-bit change matching up: step <= 1, dir <= 1, count <= count+1.
  - Single-bit change matching down: step <= 1, dir <= 0, count <= count−1.
  - Two-bit change: err <= 1, step <= 0, dir and count hold.
- **Count arithmetic:** WIDTH bits, no saturation. Wraps 2^WIDTH−1 → 0 and 0 → 2^WIDTH−1.
- **Reset values:** step = 0, err = 0, dir = 1, count = 0. s1, s2, f, cnt and prev are all 0.
- **Reset priority:** `rst` beats every other event. A reset mid-debounce discards the partial count.
- **Encoder resting at 11 through reset:** after release it produces exactly one `err` pulse and no step. This is the defined behaviour.

## Timing
- Let edge k be the first edge at which s1 samples a new level on one phase, held stable afterwards.
  - s2 changes at edge k+1.
  - f changes at edge k+1+DEBOUNCE.
  - step, dir and count update at edge k+2+DEBOUNCE.
  - With the default, that is edge k+6.
- `step` and `err` are high for exactly one cycle per event. They are never high together.
- Back-to-back transitions are supported. Phases alternating every DEBOUNCE cycles or slower produce one step per filtered change, with no loss.
- Both phases changing within the same sample window produce `err`, not two steps.
- No handshake: consumers sample `step` every cycle.

## Structure
- Package `quad_pkg`:
  - `typedef logic [1:0] quad_state_t`.
  - Localparams `UP_NEXT`/`DN_NEXT` encoding each state's successor.
  - Function `quad_decode(prev, cur)` returning {valid, dir, err}.
- Sub-module `sync_debounce #(DEBOUNCE)`: ports clk, rst, d_async, q_filtered. Instantiated once per phase.
- Top level contains the `prev` register, decode logic and output registers.

## Test plan
- **Reset:** hold rst 3 cycles with a_in = b_in = 0 → step = 0, err = 0, dir = 1, count = 0. Outputs stay there with inputs static.
- **Up rotation:** drive the full up cycle 00→10→11→01→00, each level held 10 cycles → 4 step pulses with dir = 1, count = 4. The first pulse appears exactly 6 edges after a_in is first sampled high.
- **Down with wrap:** from count = 0, drive one down transition 00→01 → count = 255, dir = 0, one step pulse.
- **Glitch rejection:** a_in high for 3 cycles then low (DEBOUNCE = 4) → no step, no err, count unchanged. A 4-cycle pulse produces a step.
- **Illegal transition:** drive a_in and b_in 0→1 on the same cycle → a single err pulse, step = 0, count and dir unchanged.
- **Reset mid-operation:** assert rst two cycles after an a_in edge and release it with a_in still high → fA settles to 1 DEBOUNCE cycles later, followed by one step, count = 1.
